// File: rtl/axi_ni_resp_scheduler.sv
// Response-side sequencer of the target NI: round-robin between AXI B and R,
// one header handshake per response, payload beats for reads, outstanding-FIFO pops.
module axi_ni_resp_scheduler #(
    parameter int MAX_SUPPORTED_IDS = 16,
    parameter int ID_WIDTH          = 4,
    parameter int DATA_WIDTH        = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         BVALID,
    input  logic [ID_WIDTH-1:0]          BID,
    input  logic [1:0]                   BRESP,
    output logic                         BREADY,
    input  logic                         RVALID,
    input  logic [ID_WIDTH-1:0]          RID,
    input  logic [1:0]                   RRESP,
    input  logic [DATA_WIDTH-1:0]        RDATA,
    input  logic                         RLAST,
    output logic                         RREADY,
    input  logic [MAX_SUPPORTED_IDS-1:0] wrr_rempty,
    input  logic [MAX_SUPPORTED_IDS-1:0] rdr_rempty,
    output logic [MAX_SUPPORTED_IDS-1:0] wrr_rinc,
    output logic [MAX_SUPPORTED_IDS-1:0] rdr_rinc,
    output logic                         hdr_valid,
    input  logic                         hdr_ready,
    output logic                         hdr_is_read,
    output logic [ID_WIDTH-1:0]          hdr_id,
    output logic [1:0]                   hdr_resp,
    output logic                         pay_valid,
    output logic [DATA_WIDTH-1:0]        pay_data,
    output logic                         pay_last,
    input  logic                         pay_ready,
    output logic                         orphan_err,
    output logic                         burst_err
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_B_HDR  = 2'd1;
    localparam logic [1:0] ST_R_HDR  = 2'd2;
    localparam logic [1:0] ST_R_DATA = 2'd3;
    localparam logic       GRANT_B   = 1'b0;
    localparam logic       GRANT_R   = 1'b1;

    logic [1:0]          state_r;
    logic                last_grant_r;
    logic [ID_WIDTH-1:0] hdr_id_r;
    logic [1:0]          hdr_resp_r;
    logic [7:0]          beat_cnt_r;
    logic                orphan_err_r;
    logic                burst_err_r;

    logic b_ok_s, r_ok_s, b_orphan_s, r_orphan_s;
    logic grant_b_s, grant_r_s, beat_xfer_s, beat_bad_s;

    function automatic logic [MAX_SUPPORTED_IDS-1:0] id_onehot(input logic [ID_WIDTH-1:0] id);
        logic [MAX_SUPPORTED_IDS-1:0] v;
        v     = '0;
        v[id] = 1'b1;
        return v;
    endfunction

    // Eligibility, arbitration and burst-beat qualification
    always_comb begin
        b_orphan_s  = BVALID && wrr_rempty[BID];
        r_orphan_s  = RVALID && rdr_rempty[RID];
        b_ok_s      = BVALID && !wrr_rempty[BID];
        r_ok_s      = RVALID && !rdr_rempty[RID];
        grant_b_s   = b_ok_s && (!r_ok_s || (last_grant_r == GRANT_R));
        grant_r_s   = r_ok_s && !grant_b_s;
        beat_xfer_s = (state_r == ST_R_DATA) && RVALID && pay_ready;
        beat_bad_s  = (RID != hdr_id_r) || ((beat_cnt_r == 8'd255) && !RLAST);
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        BREADY      = 1'b0;
        RREADY      = 1'b0;
        hdr_valid   = 1'b0;
        hdr_is_read = 1'b0;
        pay_valid   = 1'b0;
        pay_data    = '0;
        pay_last    = 1'b0;
        wrr_rinc    = '0;
        rdr_rinc    = '0;
        case (state_r)
            ST_IDLE: begin
                BREADY = 1'b0;
            end
            ST_B_HDR: begin
                hdr_valid = 1'b1;
                BREADY    = hdr_ready;
                if (hdr_ready) begin
                    wrr_rinc = id_onehot(hdr_id_r);
                end else begin
                    wrr_rinc = '0;
                end
            end
            ST_R_HDR: begin
                hdr_valid   = 1'b1;
                hdr_is_read = 1'b1;
            end
            ST_R_DATA: begin
                pay_valid = RVALID;
                pay_data  = RDATA;
                pay_last  = RLAST;
                RREADY    = pay_ready;
                if (beat_xfer_s && RLAST) begin
                    rdr_rinc = id_onehot(hdr_id_r);
                end else begin
                    rdr_rinc = '0;
                end
            end
            default: begin
                BREADY = 1'b0;
            end
        endcase
    end

    // Sequencer state, latched header fields, beat counter and sticky errors
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            last_grant_r <= GRANT_R;
            hdr_id_r     <= '0;
            hdr_resp_r   <= 2'd0;
            beat_cnt_r   <= 8'd0;
            orphan_err_r <= 1'b0;
            burst_err_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (b_orphan_s || r_orphan_s) begin
                        orphan_err_r <= 1'b1;
                    end
                    if (grant_b_s) begin
                        state_r    <= ST_B_HDR;
                        hdr_id_r   <= BID;
                        hdr_resp_r <= BRESP;
                    end else if (grant_r_s) begin
                        state_r    <= ST_R_HDR;
                        hdr_id_r   <= RID;
                        hdr_resp_r <= RRESP;
                    end
                end
                ST_B_HDR: begin
                    if (hdr_ready) begin
                        state_r      <= ST_IDLE;
                        last_grant_r <= GRANT_B;
                    end
                end
                ST_R_HDR: begin
                    if (hdr_ready) begin
                        beat_cnt_r <= 8'd0;
                        state_r    <= ST_R_DATA;
                    end
                end
                ST_R_DATA: begin
                    if (beat_xfer_s) begin
                        // A bad beat is still forwarded; only the sticky flag records it
                        if (beat_bad_s) begin
                            burst_err_r <= 1'b1;
                        end
                        if (beat_cnt_r != 8'd255) begin
                            beat_cnt_r <= beat_cnt_r + 8'd1;
                        end
                        if (RLAST) begin
                            state_r      <= ST_IDLE;
                            last_grant_r <= GRANT_R;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign hdr_id     = hdr_id_r;
    assign hdr_resp   = hdr_resp_r;
    assign orphan_err = orphan_err_r;
    assign burst_err  = burst_err_r;

endmodule

// File: doc/axi_ni_resp_scheduler.md
Name: axi_ni_resp_scheduler

Overview:
- Response-side sequencer of the target network interface (NI).
- Arbitrates round-robin between the AXI slave's write-response (B) and read-data (R) channels.
- Sequences the granted response into the NI packetizer as one header handshake, followed by payload beats for reads.
- Pops the per-ID outstanding-transaction FIFOs filled by the request side, and flags responses that match no outstanding request.

Parameters:
MAX_SUPPORTED_IDS, 16, number of AXI IDs tracked; one outstanding FIFO per ID, per direction.
ID_WIDTH, 4, AXI ID width; must satisfy 2^ID_WIDTH = MAX_SUPPORTED_IDS.
DATA_WIDTH, 32, R data width, passed through to the packetizer.

Ports:
clk  in  1  clock; everything is on the rising edge.
rst  in  1  reset, asynchronous, active-low.
BVALID  in  1  AXI write-response valid.
BID  in  ID_WIDTH  write-response ID.
BRESP  in  2  write-response code.
BREADY  out  1  write-response ready.
RVALID  in  1  AXI read-data valid.
RID  in  ID_WIDTH  read-data ID.
RRESP  in  2  read-data response code.
RDATA  in  DATA_WIDTH  read data.
RLAST  in  1  last beat of the read burst.
RREADY  out  1  read-data ready.
wrr_rempty  in  MAX_SUPPORTED_IDS  per-ID write outstanding FIFO empty.
rdr_rempty  in  MAX_SUPPORTED_IDS  per-ID read outstanding FIFO empty.
wrr_rinc  out  MAX_SUPPORTED_IDS  one-hot pop pulse, write FIFOs.
rdr_rinc  out  MAX_SUPPORTED_IDS  one-hot pop pulse, read FIFOs.
hdr_valid  out  1  response header valid to the packetizer.
hdr_ready  in  1  packetizer accepts the header.
hdr_is_read  out  1  1 = read-data packet, 0 = write-response packet.
hdr_id  out  ID_WIDTH  latched ID of the granted response.
hdr_resp  out  2  latched BRESP, or the RRESP of the first beat.
pay_valid  out  1  payload beat valid.
pay_data  out  DATA_WIDTH  payload beat; RDATA passed through.
pay_last  out  1  final payload beat.
pay_ready  in  1  packetizer accepts the beat.
orphan_err  out  1  sticky: a response arrived whose ID FIFO is empty.
burst_err  out  1  sticky: RID changed mid-burst, or more than 256 beats.

Behaviour:
- Reset: state IDLE; last_grant = R, so B wins the first tie. All outputs 0, including both sticky errors; hdr_id, hdr_resp and the beat counter are cleared. Reset is honoured in any state and abandons an in-flight packet; no pop is issued for it.
- Eligibility (combinational):
  - b_ok = BVALID && !wrr_rempty[BID].
  - r_ok = RVALID && !rdr_rempty[RID].
  - BVALID && wrr_rempty[BID], or RVALID && rdr_rempty[RID], sets orphan_err in IDLE. That response is never granted; its channel stalls.
- States:
  - IDLE: BREADY = RREADY = 0.
    - b_ok only -> B_HDR.
    - r_ok only -> R_HDR.
    - Both -> the channel not equal to last_grant.
    - On grant, latch ID and RESP from the granted channel.
    - Latency: the grant decision is registered; hdr_valid rises the cycle after the grant.
  - B_HDR: hdr_valid = 1, hdr_is_read = 0, BREADY = hdr_ready (combinational).
    - On hdr_ready: wrr_rinc[hdr_id] pulses for 1 cycle, last_grant <= B, -> IDLE.
  - R_HDR: hdr_valid = 1, hdr_is_read = 1, RREADY = 0.
    - On hdr_ready: beat_cnt <= 0, -> R_DATA.
  - R_DATA:
    - pay_valid = RVALID, pay_data = RDATA, pay_last = RLAST, RREADY = pay_ready; hdr_valid = 0.
    - Beat transfer = RVALID && pay_ready; beat_cnt increments, 8 bits, saturating.
    - Transfer with RID != hdr_id, or with beat_cnt = 255 and !RLAST: set burst_err; the beat is still forwarded.
    - Transfer with RLAST: rdr_rinc[hdr_id] pulses, last_grant <= R, -> IDLE.
  - Default: unused encodings -> IDLE.
- Throughput:
  - Back-to-back B-only traffic: one response per 2 cycles (IDLE, B_HDR).
  - Reads: 2 cycles of overhead plus 1 cycle per beat when pay_ready is held high.
- Invariants:
  - At most one bit of wrr_rinc | rdr_rinc is set in any cycle.
  - BREADY and RREADY are never high together.
  - hdr_id and hdr_resp stay constant from grant until return to IDLE.
- Simultaneous events: a B arriving during R_DATA waits for the burst to finish. On return to IDLE with both pending, B wins because last_grant = R.

Test Plan:
- Reset, then BVALID, BID=3, BRESP=0, wrr_rempty[3]=0, hdr_ready=1 -> hdr_valid high cycle 2, hdr_id=3, BREADY and wrr_rinc=0x0008 for 1 cycle, back in IDLE.
- RVALID, RID=5, 4-beat burst, pay_ready=1 -> header, then 4 beats with pay_last on beat 4, rdr_rinc=0x0020 on beat 4, RREADY never high in R_HDR.
- B(ID 1) and R(ID 2, 2 beats) pending together, repeated 3 times -> grant order B, R, B, R, B, R.
- pay_ready toggles 1010 during an 8-beat read -> every beat transferred exactly once, beat order preserved, RREADY mirrors pay_ready.
- BVALID, BID=7 with wrr_rempty[7]=1 -> orphan_err sets and stays set, BREADY stays 0, no pop; an R with a valid ID is still granted.
- rst low mid-R_DATA (beat 2 of 4) -> all outputs 0 asynchronously, no rdr_rinc, IDLE after release.
